// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, ALU codes and the decoded-slot record shared by the decode stage
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [31:0] BUBBLE = 32'h0;

    typedef struct packed {
        logic        valid;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        src_a_pc;
        logic        src_b_imm;
        logic [2:0]  funct3;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jalr;
    } dec_t;

    // alt is instr[30]; it only means SUB for register-register ops
    function automatic logic [3:0] alu_sel(input logic [2:0] funct3, input logic alt, input logic reg_op);
        case (funct3)
            3'b000:  alu_sel = (reg_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read 1-write register file, x0 hardwired to zero, write-through reads
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clock,
    input  logic              wen,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [RA_W-1:0]   raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int NREG = 1 << RA_W;

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clock) begin
        if (wen && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
        if (wen && raddr_a == waddr) rdata_a = wdata;
        if (wen && raddr_b == waddr) rdata_b = wdata;
        if (raddr_a == '0) rdata_a = '0;
        if (raddr_b == '0) rdata_b = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode: regfile, load-use hold, early JAL redirect, de_* pipeline regs
// Optional DECODE_ILLEGAL_TRAP_EN: adds de_illegal and passes illegal words as flagged slots.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] fd_pc,
    input  logic [31:0]       fd_instr,
    input  logic              dcache_stall,
    input  logic              ex_flush,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              br_en,
    output logic [DATA_W-1:0] br_addr,
    output logic              de_valid,
    output logic [DATA_W-1:0] de_pc,
    output logic [DATA_W-1:0] de_rs1_val,
    output logic [DATA_W-1:0] de_rs2_val,
    output logic [DATA_W-1:0] de_imm,
    output logic [RA_W-1:0]   de_rs1,
    output logic [RA_W-1:0]   de_rs2,
    output logic [RA_W-1:0]   de_rd,
    output logic [3:0]        de_alu_op,
    output logic              de_src_a_pc,
    output logic              de_src_b_imm,
    output logic [2:0]        de_funct3,
    output logic              de_mem_read,
    output logic              de_mem_write,
    output logic              de_reg_write,
    output logic              de_branch,
    output logic              de_jalr
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic              de_illegal
`endif
);

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = fd_instr[6:0];
    assign rd     = fd_instr[11:7];
    assign f3     = fd_instr[14:12];
    assign rs1    = fd_instr[19:15];
    assign rs2    = fd_instr[24:20];
    assign f7     = fd_instr[31:25];

    assign imm_i = {{20{fd_instr[31]}}, fd_instr[31:20]};
    assign imm_s = {{20{fd_instr[31]}}, fd_instr[31:25], fd_instr[11:7]};
    assign imm_b = {{19{fd_instr[31]}}, fd_instr[31], fd_instr[7], fd_instr[30:25], fd_instr[11:8], 1'b0};
    assign imm_u = {fd_instr[31:12], 12'b0};
    assign imm_j = {{11{fd_instr[31]}}, fd_instr[31], fd_instr[19:12], fd_instr[20], fd_instr[30:21], 1'b0};

    dec_t dec, de_q;
    logic legal, hazard;
    logic [DATA_W-1:0] rdata_a, rdata_b, pc_q, v1_q, v2_q;

    // Unused source indices are zeroed so they never alias a load destination
    always_comb begin
        dec           = '0;
        legal         = 1'b1;
        dec.valid     = 1'b1;
        dec.funct3    = f3;
        dec.rs1       = rs1;
        dec.rs2       = rs2;
        dec.rd        = rd;
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.imm       = imm_i;
        case (opcode)
            OPC_LUI:    begin dec.alu_op = ALU_PASSB; dec.imm = imm_u; dec.rs1 = '0; dec.rs2 = '0; end
            OPC_AUIPC:  begin dec.src_a_pc = 1'b1; dec.imm = imm_u; dec.rs1 = '0; dec.rs2 = '0; end
            OPC_JAL:    begin dec.src_a_pc = 1'b1; dec.imm = 32'd4; dec.rs1 = '0; dec.rs2 = '0; end
            OPC_JALR:   begin dec.jalr = 1'b1; dec.rs2 = '0; end
            OPC_BRANCH: begin
                dec.branch    = 1'b1;
                dec.alu_op    = ALU_SUB;
                dec.src_b_imm = 1'b0;
                dec.reg_write = 1'b0;
                dec.imm       = imm_b;
            end
            OPC_LOAD:   begin dec.mem_read = 1'b1; dec.rs2 = '0; end
            OPC_STORE:  begin dec.mem_write = 1'b1; dec.reg_write = 1'b0; dec.imm = imm_s; end
            OPC_OP_IMM: begin
                dec.alu_op = alu_sel(f3, fd_instr[30], 1'b0);
                if (f3[1:0] == 2'b01) dec.imm = {27'b0, rs2};
                dec.rs2 = '0;
            end
            OPC_OP:     begin
                dec.alu_op    = alu_sel(f3, f7[5], 1'b1);
                dec.src_b_imm = 1'b0;
                dec.imm       = '0;
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            end
            default:    legal = 1'b0;
        endcase
        if (rd == '0 || !dec.reg_write) begin
            dec.reg_write = 1'b0;
            dec.rd        = '0;
        end
        if (fd_instr == BUBBLE || !legal) dec = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (fd_instr != BUBBLE && !legal) dec.valid = 1'b1;
`endif
    end

    regfile_2r1w #(.DATA_W(DATA_W), .RA_W(RA_W)) u_regfile (
        .clock   (clock),
        .wen     (wb_en && !reset),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (dec.rs1),
        .rdata_a (rdata_a),
        .raddr_b (dec.rs2),
        .rdata_b (rdata_b)
    );

    assign hazard  = de_q.valid && de_q.mem_read && de_q.rd != '0 &&
                     (dec.rs1 == de_q.rd || dec.rs2 == de_q.rd);
    assign stall   = !dcache_stall && !ex_flush && hazard;
    assign br_en   = !dcache_stall && !ex_flush && !hazard && opcode == OPC_JAL;
    assign br_addr = fd_pc + imm_j;

    always_ff @(posedge clock) begin
        if (reset || (!dcache_stall && (ex_flush || hazard))) begin
            de_q <= '0;
            pc_q <= '0;
            v1_q <= '0;
            v2_q <= '0;
        end else if (!dcache_stall) begin
            de_q <= dec;
            pc_q <= dec.valid ? fd_pc : '0;
            v1_q <= rdata_a;
            v2_q <= rdata_b;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_ff @(posedge clock) begin
        if (reset || (!dcache_stall && (ex_flush || hazard))) begin
            de_illegal <= 1'b0;
        end else if (!dcache_stall) begin
            de_illegal <= (fd_instr != BUBBLE) && !legal;
        end
    end
`endif

    assign de_valid     = de_q.valid;
    assign de_pc        = pc_q;
    assign de_rs1_val   = v1_q;
    assign de_rs2_val   = v2_q;
    assign de_imm       = de_q.imm;
    assign de_rs1       = de_q.rs1;
    assign de_rs2       = de_q.rs2;
    assign de_rd        = de_q.rd;
    assign de_alu_op    = de_q.alu_op;
    assign de_src_a_pc  = de_q.src_a_pc;
    assign de_src_b_imm = de_q.src_b_imm;
    assign de_funct3    = de_q.funct3;
    assign de_mem_read  = de_q.mem_read;
    assign de_mem_write = de_q.mem_write;
    assign de_reg_write = de_q.reg_write;
    assign de_branch    = de_q.branch;
    assign de_jalr      = de_q.jalr;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized bench for decode_stage against an instruction-level model
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset, dcache_stall, ex_flush, wb_en;
    logic [31:0] fd_pc, fd_instr, wb_data;
    logic [4:0]  wb_rd;
    logic        stall, br_en;
    logic [31:0] br_addr, de_pc, de_rs1_val, de_rs2_val, de_imm;
    logic        de_valid, de_src_a_pc, de_src_b_imm;
    logic [4:0]  de_rs1, de_rs2, de_rd;
    logic [3:0]  de_alu_op;
    logic [2:0]  de_funct3;
    logic        de_mem_read, de_mem_write, de_reg_write, de_branch, de_jalr;

    int total = 0;
    int bad = 0;

    logic [31:0] mregs [32];
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0, m_pc = 32'h0, m_v1 = 32'h0, m_v2 = 32'h0;
    logic        obs_stall, obs_br;
    logic [31:0] obs_braddr;
    logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset(reset), .fd_pc(fd_pc), .fd_instr(fd_instr),
        .dcache_stall(dcache_stall), .ex_flush(ex_flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .br_en(br_en), .br_addr(br_addr),
        .de_valid(de_valid), .de_pc(de_pc), .de_rs1_val(de_rs1_val), .de_rs2_val(de_rs2_val),
        .de_imm(de_imm), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd),
        .de_alu_op(de_alu_op), .de_src_a_pc(de_src_a_pc), .de_src_b_imm(de_src_b_imm),
        .de_funct3(de_funct3), .de_mem_read(de_mem_read), .de_mem_write(de_mem_write),
        .de_reg_write(de_reg_write), .de_branch(de_branch), .de_jalr(de_jalr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        logic [31:0] f;
        f = v & ((32'h1 << n) - 32'h1);
        return f[n-1] ? f - (32'h1 << n) : f;
    endfunction

    function automatic bit legal_w(input logic [31:0] w);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
        if (w == 32'h0) return 1'b0;
        case (op)
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13: return 1'b1;
            7'h33: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit uses1(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        return legal_w(w) && (op == 7'h67 || op == 7'h63 || op == 7'h03 || op == 7'h23 || op == 7'h13 || op == 7'h33);
    endfunction

    function automatic bit uses2(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        return legal_w(w) && (op == 7'h63 || op == 7'h23 || op == 7'h33);
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        case (op)
            7'h37, 7'h17: return w & 32'hFFFFF000;
            7'h6F: return 32'd4;
            7'h67, 7'h03: return sext(w >> 20, 12);
            7'h13: return (w[14:12] == 3'd1 || w[14:12] == 3'd5) ? ((w >> 20) & 32'd31) : sext(w >> 20, 12);
            7'h23: return sext(((w >> 25) << 5) | ((w >> 7) & 32'd31), 12);
            7'h63: return sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                               (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] jal_off(input logic [31:0] w);
        return sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                    (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
    endfunction

    function automatic logic [31:0] alu_of(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h37) return 32'd10;
        if (op != 7'h13 && op != 7'h33) return 32'd0;
        case (w[14:12])
            3'd0: return (op == 7'h33 && w[30]) ? 32'd1 : 32'd0;
            3'd1: return 32'd2;
            3'd2: return 32'd3;
            3'd3: return 32'd4;
            3'd4: return 32'd5;
            3'd5: return w[30] ? 32'd7 : 32'd6;
            3'd6: return 32'd8;
            default: return 32'd9;
        endcase
    endfunction

    function automatic logic [31:0] rdm(input logic [4:0] idx, input logic we, input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (we && wr == idx) return wd;
        return mregs[idx];
    endfunction

    task automatic check_slot();
        logic [6:0] op;
        logic [4:0] rd;
        logic rw;
        op = m_instr[6:0];
        rd = m_instr[11:7];
        rw = (op != 7'h63 && op != 7'h23 && rd != 5'd0);
        chk("de_valid", de_valid, m_valid);
        if (!m_valid) begin
            chk("bubble_mem_read", de_mem_read, 0);
            chk("bubble_mem_write", de_mem_write, 0);
            chk("bubble_reg_write", de_reg_write, 0);
            chk("bubble_branch", de_branch, 0);
            chk("bubble_jalr", de_jalr, 0);
        end else begin
            chk("de_pc", de_pc, m_pc);
            chk("de_reg_write", de_reg_write, rw);
            chk("de_mem_read", de_mem_read, op == 7'h03);
            chk("de_mem_write", de_mem_write, op == 7'h23);
            chk("de_branch", de_branch, op == 7'h63);
            chk("de_jalr", de_jalr, op == 7'h67);
            if (op != 7'h33) chk("de_imm", de_imm, imm_of(m_instr));
            if (op != 7'h67 && op != 7'h63 && op != 7'h6F) begin
                chk("de_alu_op", de_alu_op, alu_of(m_instr));
                chk("de_src_b_imm", de_src_b_imm, op != 7'h33);
            end
            if (op != 7'h67 && op != 7'h63) chk("de_src_a_pc", de_src_a_pc, op == 7'h17 || op == 7'h6F);
            if (op == 7'h63 || op == 7'h03 || op == 7'h23) chk("de_funct3", de_funct3, m_instr[14:12]);
            if (uses1(m_instr)) begin
                chk("de_rs1", de_rs1, m_instr[19:15]);
                chk("de_rs1_val", de_rs1_val, m_v1);
            end
            if (uses2(m_instr)) begin
                chk("de_rs2", de_rs2, m_instr[24:20]);
                chk("de_rs2_val", de_rs2_val, m_v2);
            end
            if (rw) chk("de_rd", de_rd, rd);
        end
    endtask

    task automatic chk_zero();
        chk("rst_valid", de_valid, 0);      chk("rst_pc", de_pc, 0);
        chk("rst_rs1_val", de_rs1_val, 0);  chk("rst_rs2_val", de_rs2_val, 0);
        chk("rst_imm", de_imm, 0);          chk("rst_rs1", de_rs1, 0);
        chk("rst_rs2", de_rs2, 0);          chk("rst_rd", de_rd, 0);
        chk("rst_alu", de_alu_op, 0);       chk("rst_src_a", de_src_a_pc, 0);
        chk("rst_src_b", de_src_b_imm, 0);  chk("rst_funct3", de_funct3, 0);
        chk("rst_mem_read", de_mem_read, 0); chk("rst_mem_write", de_mem_write, 0);
        chk("rst_reg_write", de_reg_write, 0); chk("rst_branch", de_branch, 0);
        chk("rst_jalr", de_jalr, 0);
    endtask

    task automatic cycle(input logic [31:0] w, input logic [31:0] pc, input logic ds, input logic fl,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd, input logic rs);
        logic hz, jal_go;
        fd_instr = w; fd_pc = pc; dcache_stall = ds; ex_flush = fl;
        wb_en = we; wb_rd = wr; wb_data = wd; reset = rs;
        #1;
        obs_stall = stall; obs_br = br_en; obs_braddr = br_addr;
        hz = m_valid && m_instr[6:0] == 7'h03 && m_instr[11:7] != 5'd0 &&
             ((uses1(w) && w[19:15] == m_instr[11:7]) || (uses2(w) && w[24:20] == m_instr[11:7]));
        jal_go = !ds && !fl && !hz && w[6:0] == 7'h6F;
        if (!rs) begin
            chk("stall", stall, !ds && !fl && hz);
            chk("br_en", br_en, jal_go);
            if (jal_go) chk("br_addr", br_addr, pc + jal_off(w));
        end
        @(posedge clock);
        if (rs || (!ds && (fl || hz))) begin
            m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
        end else if (!ds) begin
            m_valid = legal_w(w);
            m_instr = legal_w(w) ? w : 32'h0;
            m_pc = pc;
            m_v1 = rdm(w[19:15], we, wr, wd);
            m_v2 = rdm(w[24:20], we, wr, wd);
        end
        if (we && wr != 5'd0 && !rs) mregs[wr] = wd;
        #1;
        check_slot();
    endtask

    initial begin
        cycle(32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 1);
        cycle(32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 1);
        chk_zero();
        for (int i = 1; i < 32; i++) cycle(32'h0, 32'h0, 0, 0, 1, 5'(i), $urandom, 0);

        // addi x1,x0,5
        cycle(32'h00500093, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0);
        chk("addi_valid", de_valid, 1);  chk("addi_rd", de_rd, 1);
        chk("addi_imm", de_imm, 5);      chk("addi_alu", de_alu_op, 0);
        chk("addi_src_b", de_src_b_imm, 1); chk("addi_reg_write", de_reg_write, 1);

        // jal x1,+8
        cycle(32'h008000EF, 32'h10, 0, 0, 0, 5'd0, 32'h0, 0);
        chk("jal_br_en", obs_br, 1);     chk("jal_br_addr", obs_braddr, 32'h18);
        chk("jal_pc", de_pc, 32'h10);    chk("jal_reg_write", de_reg_write, 1);

        // lw x2,0(x1) ; add x3,x2,x2
        cycle(32'h0000A103, 32'h14, 0, 0, 0, 5'd0, 32'h0, 0);
        cycle(32'h002101B3, 32'h18, 0, 0, 0, 5'd0, 32'h0, 0);
        chk("lu_stall", obs_stall, 1);   chk("lu_bubble", de_valid, 0);
        cycle(32'h002101B3, 32'h18, 0, 0, 0, 5'd0, 32'h0, 0);
        chk("lu_release", obs_stall, 0); chk("lu_add_valid", de_valid, 1);
        chk("lu_add_rs1", de_rs1, 2);    chk("lu_add_rs2", de_rs2, 2);

        // write-through x5 and x0 write
        cycle(32'h00028333, 32'h1C, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0);
        chk("wt_rs1_val", de_rs1_val, 32'hDEADBEEF);
        cycle(32'h00000333, 32'h20, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0);
        chk("x0_wt", de_rs1_val, 0);
        cycle(32'h000003B3, 32'h24, 0, 0, 0, 5'd0, 32'h0, 0);
        chk("x0_read", de_rs1_val, 0);

        // load-use under dcache_stall
        cycle(32'h0000A103, 32'h28, 0, 0, 0, 5'd0, 32'h0, 0);
        cycle(32'h002101B3, 32'h2C, 1, 0, 0, 5'd0, 32'h0, 0);
        chk("ds_stall", obs_stall, 0);   chk("ds_hold_valid", de_valid, 1);
        chk("ds_hold_pc", de_pc, 32'h28); chk("ds_hold_mr", de_mem_read, 1);
        cycle(32'h002101B3, 32'h2C, 0, 0, 0, 5'd0, 32'h0, 0);
        chk("ds_then_stall", obs_stall, 1);
        cycle(32'h002101B3, 32'h2C, 0, 0, 0, 5'd0, 32'h0, 0);

        // ex_flush with jal
        cycle(32'h008000EF, 32'h30, 0, 1, 0, 5'd0, 32'h0, 0);
        chk("fl_br_en", obs_br, 0);      chk("fl_valid", de_valid, 0);

        // reset mid-stream
        cycle(32'h0000A103, 32'h34, 0, 0, 0, 5'd0, 32'h0, 0);
        cycle(32'h0, 32'h38, 0, 0, 1, 5'd3, 32'h12345678, 1);
        chk_zero();
        cycle(32'h0, 32'h3C, 0, 0, 0, 5'd0, 32'h0, 0);
        chk("rst_stall", obs_stall, 0);  chk("rst_br_en", obs_br, 0);

        for (int n = 0; n < 500; n++) begin
            logic [31:0] w;
            int k;
            w = $urandom;
            k = $urandom_range(0, 11);
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            if (k < 9) w[6:0] = ops[k];
            else if (k == 10) w[6:0] = ($urandom_range(0, 1) == 1) ? 7'h73 : 7'h0F;
            if (k == 8 || k == 11) begin
                w[6:0] = 7'h33;
                w[31:25] = ($urandom_range(0, 3) == 0) ? 7'($urandom) :
                           (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
            end
            if (k == 9) w = 32'h0;
            cycle(w, $urandom & ~32'h3, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 63) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
